interrupt_sequencer: RTL
========================

# interrupt_sequencer

Sequences the program counter through interrupt entry and return for the MACPU core. It accepts prioritised interrupt requests and picks the vector. It drives the PC's interrupt, recovery and lock controls and keeps a LIFO of return addresses, so higher-priority interrupts can nest inside lower ones. It sits between the peripheral IRQ lines and the program counter, alongside the instruction decoder, which signals returns.

## Interface
- IRQ_NUM, 4: number of request lines; index 0 is the highest priority.
- STACK_DEPTH, 4: maximum nesting depth, i.e. return-stack entries.
- VECTOR_BASE, 16'h0010: vector address of IRQ 0.
- VECTOR_STRIDE, 16'h0004: address distance between consecutive vectors.

- clk  in  1  system clock, rising edge
- n_rst  in  1  asynchronous active-low reset
- i_irq  in  IRQ_NUM  level-sensitive requests
- i_global_en  in  1  master interrupt enable
- i_mask_wr  in  1  write strobe for the mask register
- i_mask_data  in  IRQ_NUM  new mask; 1 = masked
- i_iret  in  1  one-cycle pulse from the decoder on a return-from-interrupt
- i_save_address  in  16  PC value presented on the PC save/recovery bus during entry
- o_pc_interrupt_enable  out  1  PC loads o_pc_interrupt_address
- o_pc_interrupt_address  out  16  selected vector
- o_pc_recovery_enable  out  1  PC loads the recovery value
- o_recovery_address  out  16  popped return address, driven onto the save/recovery bus
- o_pc_lock  out  1  freezes PC increment
- o_irq_ack  out  IRQ_NUM  one-hot acknowledge pulse
- o_in_service  out  IRQ_NUM  in-service bits
- o_iret_error  out  1  sticky: i_iret received with an empty stack

## Operation
- Pending vector: i_irq & ~mask, gated by i_global_en.
- Candidate: the lowest set index of the pending vector.
- An interrupt is taken when all of the following hold:
  - state is IDLE or ACTIVE;
  - no i_iret arrives this cycle;
  - depth < STACK_DEPTH;
  - the candidate index is lower than the lowest set bit of o_in_service, or o_in_service is 0.
- States: IDLE (depth 0), ENTER, ACTIVE (depth > 0), RETURN.
- IDLE/ACTIVE -> ENTER when an interrupt is taken.
- ENTER:
  - asserts o_pc_interrupt_enable and o_irq_ack[idx];
  - o_pc_interrupt_address = VECTOR_BASE + idx*VECTOR_STRIDE, 16-bit wrap;
  - at the end of the cycle, pushes i_save_address and sets o_in_service[idx];
  - next state is ACTIVE.
- ACTIVE + i_iret -> RETURN.
- RETURN:
  - asserts o_pc_lock and o_pc_recovery_enable;
  - o_recovery_address = top of stack;
  - at the end of the cycle, pops and clears the lowest set o_in_service bit;
  - next state is ACTIVE if the new depth > 0, else IDLE.
- i_iret in IDLE: no PC action; o_iret_error is set.
- Simultaneous i_iret and a pending request: i_iret wins. The request is re-evaluated in the state after RETURN.
- Stack full with a higher-priority request pending: the request is held, not dropped. Sources keep their level asserted until acknowledged by software.
- i_mask_wr updates the mask at the clock edge. The new mask applies from the next cycle.
- Masking an in-service IRQ does not end its service.

## Timing
- Request seen at edge t: ENTER occupies cycle t..t+1. The PC holds the vector after edge t+1.
- i_iret sampled at edge t: RETURN occupies cycle t..t+1. The PC holds the return address after edge t+1.
- Back-to-back entries are possible: ENTER -> ACTIVE -> ENTER, with a minimum of 2 cycles between entries.
- All outputs are registered.
- Reset values:
  - all control outputs 0;
  - both address outputs 16'h0000;
  - o_in_service 0;
  - o_iret_error 0;
  - mask all ones (everything masked);
  - depth 0;
  - state IDLE.
- Reset asserted mid-ENTER or mid-RETURN aborts immediately. The stack contents are discarded.

## Structure
- Shared defines header holds the 2-bit state encodings and the default VECTOR_BASE and VECTOR_STRIDE.
- Sub-module irq_return_stack:
  - STACK_DEPTH x 16 LIFO;
  - push/pop ports, depth count, full/empty flags;
  - push and pop never occur in the same cycle.
- The top level contains the priority encoder, mask register and FSM.

## Test plan
- Unmask all, i_global_en=1, pc bus=16'h0123, raise i_irq[2] -> ENTER one cycle, o_pc_interrupt_address=16'h0018, o_irq_ack=4'b0100, o_in_service=4'b0100.
- During service of IRQ 2, raise i_irq[0] with bus=16'h0019 -> nested entry to 16'h0010, depth 2. Two i_iret pulses -> recovery addresses 16'h0019 then 16'h0123, ending in IDLE.
- During IRQ 0 service, raise i_irq[3] -> no entry until after the final return.
- STACK_DEPTH=2: nest IRQ 3 then IRQ 1, then raise IRQ 0 -> held with no ack. After one i_iret it is taken.
- i_iret while IDLE -> no PC controls asserted, o_iret_error=1.
- Assert n_rst during RETURN -> all outputs 0 immediately, mask all ones, subsequent i_irq ignored until unmasked.

Source files
------------

// File: rtl/interrupt_sequencer_pkg.sv
// interrupt_sequencer shared definitions
// FSM state encodings, default vector layout, vector address helper
package interrupt_sequencer_pkg;

    localparam int ADDR_W = 16;

    localparam logic [ADDR_W-1:0] DEF_VECTOR_BASE   = 16'h0010;
    localparam logic [ADDR_W-1:0] DEF_VECTOR_STRIDE = 16'h0004;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ENTER  = 2'b01,
        ST_ACTIVE = 2'b10,
        ST_RETURN = 2'b11
    } seq_state_t;

    // Vector address, wrapping in 16 bits.
    function automatic logic [ADDR_W-1:0] vector_addr(
        input logic [ADDR_W-1:0] base,
        input logic [ADDR_W-1:0] stride,
        input logic [ADDR_W-1:0] idx
    );
        return base + stride * idx;
    endfunction

endpackage

// File: rtl/interrupt_sequencer_if.sv
// interrupt_sequencer <-> program counter bus
// master: sequencer side, slave: PC side
interface interrupt_sequencer_if;
    import interrupt_sequencer_pkg::*;

    logic              o_pc_interrupt_enable;
    logic [ADDR_W-1:0] o_pc_interrupt_address;
    logic              o_pc_recovery_enable;
    logic [ADDR_W-1:0] o_recovery_address;
    logic              o_pc_lock;
    logic [ADDR_W-1:0] i_save_address;

    modport master (
        output o_pc_interrupt_enable,
        output o_pc_interrupt_address,
        output o_pc_recovery_enable,
        output o_recovery_address,
        output o_pc_lock,
        input  i_save_address
    );

    modport slave (
        input  o_pc_interrupt_enable,
        input  o_pc_interrupt_address,
        input  o_pc_recovery_enable,
        input  o_recovery_address,
        input  o_pc_lock,
        output i_save_address
    );

endinterface

// File: rtl/interrupt_sequencer_irq_return_stack.sv
// irq_return_stack: LIFO of interrupt return addresses
// push and pop are never requested in the same cycle
module irq_return_stack #(
    parameter int STACK_DEPTH = 4,
    parameter int WIDTH       = 16,
    parameter int DW          = $clog2(STACK_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top,
    output logic [DW-1:0]    depth,
    output logic             full,
    output logic             empty
);

    localparam int AW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [WIDTH-1:0] mem [STACK_DEPTH];
    logic [DW-1:0]    cnt;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign wr_ptr  = AW'(cnt);
    assign rd_ptr  = AW'(cnt - DW'(1));
    assign full    = (cnt == DW'(STACK_DEPTH));
    assign empty   = (cnt == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign top     = mem[rd_ptr];
    assign depth   = cnt;

    // Entry count; reset discards all stacked addresses.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt <= '0;
        end else if (do_push) begin
            cnt <= cnt + DW'(1);
        end else if (do_pop) begin
            cnt <= cnt - DW'(1);
        end
    end

    // Storage array, contents only meaningful below cnt.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/interrupt_sequencer.sv
// interrupt_sequencer: prioritised entry/return sequencing for the PC
// priority encoder, mask register, FSM and nesting return stack
module interrupt_sequencer
    import interrupt_sequencer_pkg::*;
#(
    parameter int                IRQ_NUM       = 4,
    parameter int                STACK_DEPTH   = 4,
    parameter logic [ADDR_W-1:0] VECTOR_BASE   = DEF_VECTOR_BASE,
    parameter logic [ADDR_W-1:0] VECTOR_STRIDE = DEF_VECTOR_STRIDE
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic [IRQ_NUM-1:0]   i_irq,
    input  logic                 i_global_en,
    input  logic                 i_mask_wr,
    input  logic [IRQ_NUM-1:0]   i_mask_data,
    input  logic                 i_iret,
    interrupt_sequencer_if.master pc,
    output logic [IRQ_NUM-1:0]   o_irq_ack,
    output logic [IRQ_NUM-1:0]   o_in_service,
    output logic                 o_iret_error
);

    localparam int DW = $clog2(STACK_DEPTH + 1);
    localparam int IW = (IRQ_NUM > 1) ? $clog2(IRQ_NUM) : 1;

    seq_state_t        state;
    logic [IRQ_NUM-1:0] mask;
    logic [IRQ_NUM-1:0] pend;
    logic [IRQ_NUM-1:0] cand_oh;
    logic [IRQ_NUM-1:0] svc_oh;
    logic [IW-1:0]      cand_idx;
    logic               higher;
    logic               take;
    logic               push;
    logic               pop;
    logic [ADDR_W-1:0]  stk_top;
    logic [DW-1:0]      stk_depth;
    logic               stk_full;
    logic               stk_empty;

    assign pend = i_global_en ? (i_irq & ~mask) : '0;

    // Isolate lowest set bit: lower index means higher priority,
    // so comparing one-hot values compares priorities.
    assign cand_oh = pend & (~pend + IRQ_NUM'(1));
    assign svc_oh  = o_in_service & (~o_in_service + IRQ_NUM'(1));
    assign higher  = (o_in_service == '0) || (cand_oh < svc_oh);

    assign take = (pend != '0)
               && ((state == ST_IDLE) || (state == ST_ACTIVE))
               && !i_iret
               && !stk_full
               && higher;

    assign push = (state == ST_ENTER);
    assign pop  = (state == ST_RETURN) && !stk_empty;

    // Priority encoder: index of the lowest pending line.
    always_comb begin
        cand_idx = '0;
        for (int i = IRQ_NUM - 1; i >= 0; i--) begin
            if (pend[i]) begin
                cand_idx = IW'(i);
            end
        end
    end

    irq_return_stack #(
        .STACK_DEPTH (STACK_DEPTH),
        .WIDTH       (ADDR_W),
        .DW          (DW)
    ) u_stack (
        .clk       (clk),
        .n_rst     (n_rst),
        .push      (push),
        .pop       (pop),
        .push_data (pc.i_save_address),
        .top       (stk_top),
        .depth     (stk_depth),
        .full      (stk_full),
        .empty     (stk_empty)
    );

    // Sequencer FSM with registered PC controls, mask and service bits.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state                     <= ST_IDLE;
            mask                      <= '1;
            o_irq_ack                 <= '0;
            o_in_service              <= '0;
            o_iret_error              <= 1'b0;
            pc.o_pc_interrupt_enable  <= 1'b0;
            pc.o_pc_interrupt_address <= '0;
            pc.o_pc_recovery_enable   <= 1'b0;
            pc.o_recovery_address     <= '0;
            pc.o_pc_lock              <= 1'b0;
        end else begin
            if (i_mask_wr) begin
                mask <= i_mask_data;
            end
            o_irq_ack               <= '0;
            pc.o_pc_interrupt_enable <= 1'b0;
            pc.o_pc_recovery_enable  <= 1'b0;
            pc.o_pc_lock             <= 1'b0;
            unique case (state)
                ST_IDLE, ST_ACTIVE: begin
                    if (i_iret) begin
                        if (state == ST_IDLE) begin
                            o_iret_error <= 1'b1;
                        end else begin
                            state                   <= ST_RETURN;
                            pc.o_pc_lock            <= 1'b1;
                            pc.o_pc_recovery_enable <= 1'b1;
                            pc.o_recovery_address   <= stk_top;
                        end
                    end else if (take) begin
                        state                     <= ST_ENTER;
                        o_irq_ack                 <= cand_oh;
                        pc.o_pc_interrupt_enable  <= 1'b1;
                        pc.o_pc_interrupt_address <= vector_addr(
                            VECTOR_BASE,
                            VECTOR_STRIDE,
                            ADDR_W'(cand_idx)
                        );
                    end
                end
                ST_ENTER: begin
                    o_in_service <= o_in_service | o_irq_ack;
                    state        <= ST_ACTIVE;
                end
                ST_RETURN: begin
                    o_in_service <= o_in_service & (o_in_service - IRQ_NUM'(1));
                    state        <= (stk_depth > DW'(1)) ? ST_ACTIVE : ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
